// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared between the ALU decoder and the HI/LO unit.
//   - MIPS funct codes for the HI/LO instruction group
//   - FSM state encoding of the iterative multiply/divide unit
package alu_pkg;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

endpackage

// File: rtl/alu_hilo_muldiv_if.sv
// alu_hilo_muldiv_if: execute-stage request/response bundle of the HI/LO unit.
//   Valid_in/Func_in/A_in/B_in : request from EX (master -> slave)
//   Ready_out/Busy_out         : handshake/stall status (slave -> master)
//   Valid_out/O_out/DivZero_out: completion pulse and result (slave -> master)
interface alu_hilo_muldiv_if #(parameter int WIDTH = 32);
  logic             Valid_in;
  logic [5:0]       Func_in;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic             Ready_out;
  logic             Busy_out;
  logic             Valid_out;
  logic [WIDTH-1:0] O_out;
  logic             DivZero_out;

  modport master (output Valid_in, Func_in, A_in, B_in,
                  input  Ready_out, Busy_out, Valid_out, O_out, DivZero_out);
  modport slave  (input  Valid_in, Func_in, A_in, B_in,
                  output Ready_out, Busy_out, Valid_out, O_out, DivZero_out);
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: unsigned magnitude datapath, one bit per step.
//   start  : load a_mag/b_mag, select multiply or divide, clear counter
//   step   : perform one iteration
//   last   : current step is the final (WIDTH-th) one
//   hi/lo  : multiply -> {hi,lo} = a_mag*b_mag
//            divide   -> hi = remainder, lo = quotient
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             step,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] opb;
  logic             div_r;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   sum, shifted, diff;

  // Multiply: lo holds the remaining multiplier bits, product grows into hi.
  // Divide: lo shifts the dividend out at the top and the quotient in at the
  // bottom; hi is the partial remainder. Since rem < divisor, the trial
  // difference fits in WIDTH+1 bits and its MSB is the borrow.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, opb};
  end

  assign last = (cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      opb   <= '0;
      div_r <= 1'b0;
      cnt   <= '0;
    end else if (start) begin
      hi    <= '0;
      lo    <= a_mag;
      opb   <= b_mag;
      div_r <= is_div;
      cnt   <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (div_r) begin
        if (diff[WIDTH]) begin
          hi <= shifted[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b0};
        end else begin
          hi <= diff[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b1};
        end
      end else begin
        {hi, lo} <= {sum, lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_hilo_muldiv.sv
// alu_hilo_muldiv: MIPS HI/LO unit (MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO).
//   Clk_in     : clock, rising edge
//   Reset_n_in : asynchronous active-low reset
//   bus        : request/response bundle (slave side)
// Single-cycle ops complete on the accepting edge. Multiply/divide run
// IDLE -> CALC (WIDTH cycles) -> FIX -> DONE, giving WIDTH+2 cycles latency.
module alu_hilo_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               Clk_in,
  input  logic               Reset_n_in,
  alu_hilo_muldiv_if.slave   bus
);

  state_t           state;
  logic [WIDTH-1:0] hi_r, lo_r, o_r;
  logic             vld_r, dz_r;
  logic             is_div_r, neg_a_r, neg_b_r;

  logic             f_mul, f_div, f_sgn, b_zero, start;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             it_last;
  logic [WIDTH-1:0] it_hi, it_lo;
  logic [2*WIDTH-1:0] prod, hilo_fix;
  logic [WIDTH-1:0] q_fix, r_fix;

  // Decode and operand magnitudes. Negating the most-negative value wraps
  // back to itself, which is already its correct unsigned magnitude.
  always_comb begin
    f_mul  = (bus.Func_in == F_MULT) || (bus.Func_in == F_MULTU);
    f_div  = (bus.Func_in == F_DIV)  || (bus.Func_in == F_DIVU);
    f_sgn  = (bus.Func_in == F_MULT) || (bus.Func_in == F_DIV);
    b_zero = (bus.B_in == '0);
    a_neg  = f_sgn && bus.A_in[WIDTH-1];
    b_neg  = f_sgn && bus.B_in[WIDTH-1];
    a_mag  = a_neg ? -bus.A_in : bus.A_in;
    b_mag  = b_neg ? -bus.B_in : bus.B_in;
    start  = (state == IDLE) && bus.Valid_in && (f_mul || (f_div && !b_zero));
  end

  muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk    (Clk_in),
    .rst_n  (Reset_n_in),
    .start  (start),
    .is_div (f_div),
    .step   (state == CALC),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .last   (it_last),
    .hi     (it_hi),
    .lo     (it_lo)
  );

  // Sign fix-up: product/quotient negative when operand signs differ,
  // remainder takes the sign of the dividend. DIV most-negative / -1 falls
  // out naturally: magnitude quotient 2^(W-1) negated wraps to itself.
  always_comb begin
    prod     = {it_hi, it_lo};
    q_fix    = (neg_a_r ^ neg_b_r) ? -it_lo : it_lo;
    r_fix    = neg_a_r ? -it_hi : it_hi;
    hilo_fix = is_div_r ? {r_fix, q_fix}
                        : ((neg_a_r ^ neg_b_r) ? -prod : prod);
  end

  always_ff @(posedge Clk_in or negedge Reset_n_in) begin
    if (!Reset_n_in) begin
      state    <= IDLE;
      hi_r     <= '0;
      lo_r     <= '0;
      o_r      <= '0;
      vld_r    <= 1'b0;
      dz_r     <= 1'b0;
      is_div_r <= 1'b0;
      neg_a_r  <= 1'b0;
      neg_b_r  <= 1'b0;
    end else begin
      vld_r <= 1'b0;
      dz_r  <= 1'b0;
      unique case (state)
        IDLE: if (bus.Valid_in) begin
          if (start) begin
            // O_out keeps its old value until the DONE pulse
            state    <= CALC;
            is_div_r <= f_div;
            neg_a_r  <= a_neg;
            neg_b_r  <= b_neg;
          end else begin
            vld_r <= 1'b1;
            o_r   <= '0;
            case (bus.Func_in)
              F_MFHI: o_r  <= hi_r;
              F_MFLO: o_r  <= lo_r;
              F_MTHI: hi_r <= bus.A_in;
              F_MTLO: lo_r <= bus.A_in;
              F_DIV, F_DIVU: dz_r <= 1'b1;  // only reachable with B_in == 0
              default: ;
            endcase
          end
        end
        CALC: if (it_last) state <= FIX;
        FIX: begin
          {hi_r, lo_r} <= hilo_fix;
          state        <= DONE;
        end
        DONE: begin
          vld_r <= 1'b1;
          o_r   <= lo_r;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Ready_out   = (state == IDLE);
  assign bus.Busy_out    = (state != IDLE);
  assign bus.Valid_out   = vld_r;
  assign bus.O_out       = o_r;
  assign bus.DivZero_out = dz_r;

endmodule

// File: tb/tb_alu_hilo_muldiv.sv
// tb_alu_hilo_muldiv: self-checking bench for alu_hilo_muldiv (WIDTH=32).
// Reference model keeps HI/LO as plain variables and computes results with
// 64-bit integer arithmetic.
module tb_alu_hilo_muldiv;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  alu_hilo_muldiv_if #(.WIDTH(32)) bus ();

  alu_hilo_muldiv #(.WIDTH(32)) dut (
    .Clk_in     (clk),
    .Reset_n_in (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model(input logic [5:0] f, input logic [31:0] a, b,
                       output logic [31:0] eo, output logic edz, output int elat);
    longint sa, sb, q, r;
    logic [63:0] p;
    eo = '0; edz = 1'b0; elat = 0;
    case (f)
      F_MFHI: eo = m_hi;
      F_MFLO: eo = m_lo;
      F_MTHI: m_hi = a;
      F_MTLO: m_lo = a;
      F_MULT: begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        p = 64'(sa * sb);
        {m_hi, m_lo} = p; eo = m_lo; elat = 34;
      end
      F_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        {m_hi, m_lo} = p; eo = m_lo; elat = 34;
      end
      F_DIV, F_DIVU: begin
        if (b == 32'd0) edz = 1'b1;
        else begin
          if (f == F_DIV) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
          end else begin
            sa = longint'({32'd0, a}); sb = longint'({32'd0, b});
          end
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0]; eo = m_lo; elat = 34;
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- drivers (no checking of results) ----------------
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (bus.Ready_out !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (bus.Ready_out !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: Ready_out=%b expected 1", bus.Ready_out);
    end
  endtask

  // Issue one request; lat = k where Valid_out is seen in the cycle after
  // accepting edge E+k (-1 if never seen).
  task automatic issue(input logic [5:0] f, input logic [31:0] a, b,
                       output logic [31:0] o, output logic dz, output int lat);
    wait_ready();
    bus.Valid_in = 1'b1; bus.Func_in = f; bus.A_in = a; bus.B_in = b;
    @(posedge clk); #1;
    bus.Valid_in = 1'b0; bus.A_in = $urandom; bus.B_in = $urandom;
    lat = -1; o = 'x; dz = 1'bx;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.Valid_out === 1'b1) begin
        lat = k; o = bus.O_out; dz = bus.DivZero_out; break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.Valid_in = 1'b0; bus.Func_in = '0; bus.A_in = '0; bus.B_in = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp += 5;
    if (bus.Ready_out !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b expected 1", bus.Ready_out); end
    if (bus.Busy_out !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", bus.Busy_out); end
    if (bus.Valid_out !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", bus.Valid_out); end
    if (bus.DivZero_out !== 1'b0) begin n_bad++; $display("FAIL rst_divzero: got %b expected 0", bus.DivZero_out); end
    if (bus.O_out !== 32'h0) begin n_bad++; $display("FAIL rst_o: got %h expected 0", bus.O_out); end
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_directed();
    logic [5:0]  f[10];
    logic [31:0] a[10], b[10];
    logic [31:0] o, eo; logic dz, edz; int lat, elat;
    f = '{F_MULTU, F_MFHI, F_MULT, F_MFHI, F_MULT, F_MFHI, F_DIV, F_MFHI, F_DIVU, F_MFHI};
    a = '{32'hFFFFFFFF, 0, -32'sd3, 0, 32'h80000000, 0, -32'sd7, 0, 32'd7, 0};
    b = '{32'hFFFFFFFF, 0, 32'd7, 0, 32'h80000000, 0, 32'd2, 0, 32'd2, 0};
    for (int i = 0; i < 10; i++) begin
      model(f[i], a[i], b[i], eo, edz, elat);
      issue(f[i], a[i], b[i], o, dz, lat);
      n_cmp += 2;
      if (o !== eo) begin n_bad++; $display("FAIL dir_o[%0d] f=%b: got %h expected %h", i, f[i], o, eo); end
      if (lat !== elat) begin n_bad++; $display("FAIL dir_lat[%0d]: got %0d expected %0d", i, lat, elat); end
    end
    // signed overflow case
    model(F_DIV, 32'h80000000, 32'hFFFFFFFF, eo, edz, elat);
    issue(F_DIV, 32'h80000000, 32'hFFFFFFFF, o, dz, lat);
    n_cmp++;
    if (o !== 32'h80000000) begin n_bad++; $display("FAIL div_ovf_lo: got %h expected 80000000", o); end
    issue(F_MFHI, 0, 0, o, dz, lat);
    n_cmp++;
    if (o !== 32'h0) begin n_bad++; $display("FAIL div_ovf_hi: got %h expected 0", o); end
    m_hi = 32'h0; m_lo = 32'h80000000;
  endtask

  task automatic test_divzero();
    logic [31:0] o, eo; logic dz, edz; int lat, elat;
    issue(F_MTHI, 32'h1234, 0, o, dz, lat); model(F_MTHI, 32'h1234, 0, eo, edz, elat);
    issue(F_MTLO, 32'h5678, 0, o, dz, lat); model(F_MTLO, 32'h5678, 0, eo, edz, elat);
    n_cmp++;
    if (o !== 32'h0) begin n_bad++; $display("FAIL mtlo_o: got %h expected 0", o); end
    issue(F_DIV, 32'd5, 32'd0, o, dz, lat);
    n_cmp += 3;
    if (dz !== 1'b1) begin n_bad++; $display("FAIL dz_flag: got %b expected 1", dz); end
    if (lat !== 0) begin n_bad++; $display("FAIL dz_lat: got %0d expected 0", lat); end
    if (o !== 32'h0) begin n_bad++; $display("FAIL dz_o: got %h expected 0", o); end
    issue(F_MFHI, 0, 0, o, dz, lat);
    n_cmp += 2;
    if (o !== 32'h1234) begin n_bad++; $display("FAIL dz_hi: got %h expected 1234", o); end
    if (dz !== 1'b0) begin n_bad++; $display("FAIL dz_clear: got %b expected 0", dz); end
    issue(F_MFLO, 0, 0, o, dz, lat);
    n_cmp++;
    if (o !== 32'h5678) begin n_bad++; $display("FAIL dz_lo: got %h expected 5678", o); end
  endtask

  task automatic test_random();
    logic [5:0] ops[9];
    logic [5:0] f; logic [31:0] a, b, o, eo; logic dz, edz; int lat, elat, sel;
    ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, F_MTHI, F_MTLO, 6'b101010};
    for (int i = 0; i < 40; i++) begin
      f = ops[$urandom_range(0, 8)];
      a = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = $urandom_range(1, 15);
        3: a = 32'h80000000;
        default: b = $urandom;
      endcase
      if (sel == 3) b = $urandom;
      model(f, a, b, eo, edz, elat);
      issue(f, a, b, o, dz, lat);
      n_cmp += 3;
      if (o !== eo) begin n_bad++; $display("FAIL rnd_o[%0d] f=%b a=%h b=%h: got %h expected %h", i, f, a, b, o, eo); end
      if (dz !== edz) begin n_bad++; $display("FAIL rnd_dz[%0d]: got %b expected %b", i, dz, edz); end
      if (lat !== elat) begin n_bad++; $display("FAIL rnd_lat[%0d]: got %0d expected %0d", i, lat, elat); end
    end
  endtask

  task automatic test_hold_toggle();
    logic [31:0] a0, b0, o, eo; logic dz, edz; int lat, elat; bit ready_bad;
    a0 = $urandom; b0 = $urandom;
    model(F_MULT, a0, b0, eo, edz, elat);
    wait_ready();
    bus.Valid_in = 1'b1; bus.Func_in = F_MULT; bus.A_in = a0; bus.B_in = b0;
    @(posedge clk); #1;
    bus.Func_in = F_MTLO; bus.Valid_in = 1'b0;
    ready_bad = 0; lat = -1; o = 'x;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.Valid_out === 1'b1) begin lat = k; o = bus.O_out; break; end
      if (bus.Ready_out !== 1'b0) ready_bad = 1;
      bus.Valid_in = (k < 32) ? ~bus.Valid_in : 1'b0;
      bus.A_in = $urandom; bus.B_in = $urandom;
    end
    bus.Valid_in = 1'b0;
    n_cmp += 3;
    if (ready_bad) begin n_bad++; $display("FAIL hold_ready: got 1 while busy expected 0"); end
    if (lat !== 34) begin n_bad++; $display("FAIL hold_lat: got %0d expected 34", lat); end
    if (o !== eo) begin n_bad++; $display("FAIL hold_lo: got %h expected %h", o, eo); end
    issue(F_MFHI, 0, 0, o, dz, lat);
    n_cmp++;
    if (o !== m_hi) begin n_bad++; $display("FAIL hold_hi: got %h expected %h", o, m_hi); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] o, eo; logic dz, edz; int lat, elat; bit seen;
    issue(F_MTHI, 32'hA5A5, 0, o, dz, lat); model(F_MTHI, 32'hA5A5, 0, eo, edz, elat);
    issue(F_MFHI, 0, 0, o, dz, lat);        // O_out now non-zero
    wait_ready();
    bus.Valid_in = 1'b1; bus.Func_in = F_MULT; bus.A_in = $urandom; bus.B_in = $urandom;
    @(posedge clk); #1;
    bus.Valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 4;
    if (bus.O_out !== 32'h0) begin n_bad++; $display("FAIL mid_rst_o: got %h expected 0", bus.O_out); end
    if (bus.Busy_out !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b expected 0", bus.Busy_out); end
    if (bus.Ready_out !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready: got %b expected 1", bus.Ready_out); end
    if (bus.Valid_out !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b expected 0", bus.Valid_out); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.Valid_out !== 1'b0) seen = 1;
    end
    n_cmp += 2;
    if (seen) begin n_bad++; $display("FAIL mid_rst_novalid: got Valid_out=1 expected none"); end
    if (bus.Ready_out !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready_after: got %b expected 1", bus.Ready_out); end
    issue(F_MFLO, 0, 0, o, dz, lat);
    n_cmp++;
    if (o !== 32'h0) begin n_bad++; $display("FAIL mid_rst_lo: got %h expected 0", o); end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  f[4];
    logic [31:0] a[4];
    logic [31:0] eo; logic edz; int elat;
    f = '{F_MTHI, F_MTLO, F_MFHI, F_MFLO};
    a[0] = $urandom; a[1] = $urandom; a[2] = $urandom; a[3] = $urandom;
    wait_ready();
    for (int i = 0; i < 4; i++) begin
      bus.Valid_in = 1'b1; bus.Func_in = f[i]; bus.A_in = a[i]; bus.B_in = $urandom;
      model(f[i], a[i], 32'd0, eo, edz, elat);
      @(posedge clk);
      @(negedge clk);
      n_cmp += 2;
      if (bus.Valid_out !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, bus.Valid_out); end
      if (bus.O_out !== eo) begin n_bad++; $display("FAIL b2b_o[%0d]: got %h expected %h", i, bus.O_out, eo); end
    end
    bus.Valid_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_divzero();
    test_random();
    test_hold_toggle();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_hilo_muldiv.md
# alu_hilo_muldiv

Parametrised multi-cycle companion to the combinational 32-bit ALU. It executes the MIPS HI/LO instruction group: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. The datapath width is configurable. The unit owns the HI and LO architectural registers and talks to the execute stage through a valid/ready handshake. It sits beside the ALU in EX and stalls the pipeline through Ready_out while an iterative multiply or divide is in flight.

## Interface
- WIDTH, 32, operand/HI/LO width; even, ≥4
- CNT_W, $clog2(WIDTH), iteration counter width (derived; do not override)

- Clk_in  input  1  clock, rising edge
- Reset_n_in  input  1  asynchronous, active-low reset
- Valid_in  input  1  request present
- Func_in  input  6  MIPS funct: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011
- A_in  input  WIDTH  rs operand (dividend/multiplicand; MTHI/MTLO source)
- B_in  input  WIDTH  rt operand (divisor/multiplier)
- Ready_out  output  1  request can be accepted this cycle
- Busy_out  output  1  iterative operation in flight
- Valid_out  output  1  one-cycle completion pulse
- O_out  output  WIDTH  result (MFHI/MFLO value; LO after mul/div; 0 otherwise)
- DivZero_out  output  1  qualifies Valid_out: divide by zero

## Operation
- A request is accepted on a rising edge when Valid_in && Ready_out. Ready_out = (state == IDLE).
- States:
  - IDLE: accepts requests.
  - CALC: WIDTH iterations, one bit per cycle.
  - FIX: sign correction and HI/LO write.
  - DONE: Valid_out pulse.
  - DONE always returns to IDLE.
- Single-cycle ops stay in IDLE and register Valid_out=1 on the accepting edge:
  - MFHI/MFLO: O_out=HI/LO.
  - MTHI/MTLO: HI/LO←A_in, O_out=0.
  - Undefined funct: O_out=0, no state change.
- MULT/MULTU: shift-add on operand magnitudes. Signed: result negated in FIX if sign(A)^sign(B). The 2·WIDTH product is written as {HI,LO}.
- DIV/DIVU: restoring division on magnitudes. LO=quotient, truncated toward zero. HI=remainder, with the sign of the dividend.
- Signed overflow: DIV of most-negative by −1 gives LO=most-negative, HI=0.
- B_in==0 on DIV/DIVU: no iteration. Valid_out and DivZero_out pulse on the next cycle; HI/LO unchanged; O_out=0.
- Valid_in while not Ready_out is ignored. The requester must hold it.
- Operands and signedness are latched at acceptance. Later input changes have no effect.

## Timing
- Reset (async assert, synchronous deassert handled upstream) forces:
  - state IDLE
  - HI=LO=0, O_out=0
  - Valid_out=0, DivZero_out=0, Busy_out=0
- Ready_out is 1 during reset.
- Reset mid-operation aborts the operation, produces no Valid_out, and discards the partial result.
- Single-cycle ops: Valid_out high in the cycle after the accepting edge. Back-to-back acceptance every cycle is allowed.
- MUL/DIV accepted on edge E:
  - CALC from E+1 to E+WIDTH
  - FIX at E+WIDTH+1
  - Valid_out high for one cycle after edge E+WIDTH+2, with O_out=LO
- Latency is WIDTH+2 cycles, independent of operand values.
- Busy_out = state ∈ {CALC, FIX, DONE}. Ready_out returns high in the cycle after DONE.
- MFHI/MFLO accepted after a completed mul/div returns the new value. No forwarding hazard exists because Ready_out blocks acceptance until then.
- O_out holds its last value when Valid_out=0.

## Structure
- Shared package alu_pkg holds:
  - funct localparams (shared with the existing ALU decoder)
  - state enum {IDLE, CALC, FIX, DONE}
- Sub-module muldiv_iter(WIDTH) holds the magnitude shift-add/restoring-divide datapath and the counter. The top level owns:
  - handshake and FSM
  - HI/LO registers
  - sign fix-up
  - single-cycle ops

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF, then MFHI: HI=0xFFFFFFFE, LO=0x00000001, Valid_out exactly 34 cycles after acceptance, O_out=0x00000001. The following MFHI returns 0xFFFFFFFE next cycle.
- MULT −3×7: HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000×0x80000000: HI=0x40000000, LO=0.
- DIV −7/2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2: LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI 0x1234 and MTLO 0x5678, then DIV 5/0: DivZero_out=1 with Valid_out one cycle later. MFHI/MFLO then return 0x1234/0x5678.
- During a MULT, toggle Valid_in and A_in every cycle: Ready_out=0 and the requests are ignored; the result matches the latched operands.
- Assert Reset_n_in low for 2 cycles at CALC cycle 10: outputs are zero immediately and no Valid_out is seen. After release, Ready_out=1 and MFLO returns 0.
